dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter and sequencer in front of the single-port byte-addressed data memory (dmem).
//  Port 0 is the CPU load/store unit; port 1 is the loader/debug master.
//  Each access runs a fixed 3-state sequence: latch the request, drive dmem, return the response.
//  Also range-checks the address and validates ctrl so that illegal accesses never reach dmem.
// PARAMETERS
//  ADDR_LIMIT  4096  highest valid byte address in dmem (inclusive)
//  PRIO_FIXED  0     0: round-robin between ports; 1: port 0 always wins a tie
// PORTS
//  CLK         in   1   clock; all state updates on posedge
//  RST         in   1   synchronous, active-high reset
//  p0_req      in   1   port 0 request; held high until p0_ack
//  p0_we       in   1   port 0: 1=store, 0=load
//  p0_addr     in   32  port 0 byte address
//  p0_wdata    in   32  port 0 store data
//  p0_ctrl     in   3   port 0 size/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
//  p0_ack      out  1   port 0 one-cycle completion pulse
//  p0_err      out  1   port 0 error, valid with p0_ack
//  p0_rdata    out  32  port 0 load data, valid with p0_ack
//  p1_*        -    -   same set of signals as p0_*, for port 1
//  m_addr      out  32  dmem address
//  m_w_data    out  32  dmem write data
//  m_ctrl      out  3   dmem ctrl
//  m_w_en      out  1   dmem write enable
//  m_outdata   in   32  dmem combinational read data
//  busy        out  1   high when state != IDLE
//  grant_id    out  1   port owning the current or last transaction
// BEHAVIOUR
//  States: IDLE -> ACCESS -> DONE -> IDLE. Every transaction takes 3 cycles; no pipelining.
//  IDLE:
//   - On a posedge with p0_req|p1_req: latch the winner's we/addr/wdata/ctrl into *_q.
//   - Set grant_id to the winner; go to ACCESS.
//   - Tie, PRIO_FIXED=0: grant the port != last grant. Tie, PRIO_FIXED=1: grant port 0.
//  Size: ctrl 000/100 -> 1 byte; 001/101 -> 2 bytes; 010 -> 4 bytes.
//   - ctrl 011/110/111 -> err_q=1.
//   - addr_q+size-1 > ADDR_LIMIT -> err_q=1. Compute in 33 bits; no wrap at 2^32.
//  m_addr/m_w_data/m_ctrl = *_q at all times.
//   - m_w_en = (state==ACCESS) & we_q & ~err_q.
//   - Exactly one write edge per store.
//  ACCESS:
//   - On the posedge: dmem commits the store.
//   - rdata_q <= (we_q|err_q) ? 0 : m_outdata.
//   - ack of grant_id <= 1; err <= err_q; go to DONE.
//  DONE:
//   - pX_ack/pX_err/pX_rdata valid for exactly this cycle; requests ignored.
//   - Go to IDLE on the next posedge.
//  Requester handshake:
//   - The requester drops req at the posedge ending its ack cycle.
//   - A req still high in IDLE is a new request.
//  The losing port's req stays pending and is served next; no request is ever dropped.
//  Reset values: state IDLE; *_q 0; rdata 0; acks/errs 0; busy 0; m_w_en 0.
//   - grant_id 1, so port 0 wins the first tie.
//  RST in ACCESS: the store at that same edge still commits (dmem has no reset).
//   - No ack is issued; the state returns to IDLE.
//  Non-granted port outputs: ack=0, err=0, rdata holds its last value.
// TESTING
//  1. Reset, then p0 sw addr 0x10 wdata 0xDEADBEEF ctrl 010.
//     -> m_w_en high 1 cycle; p0_ack at cycle 3; err=0.
//     Then p0 lw 0x10 -> p0_rdata 0xDEADBEEF.
//  2. p0 lb 0x10 ctrl 000 -> rdata 0xFFFFFFEF.
//     p0 lbu ctrl 100 -> 0x000000EF. p1 lhu 0x12 ctrl 101 -> 0x0000DEAD.
//  3. p0 and p1 req in the same cycle, 4 back-to-back each, PRIO_FIXED=0.
//     -> grants 0,1,0,1,...; each ack 3 cycles apart.
//     With PRIO_FIXED=1 -> all p0 transactions first.
//  4. p1 sw at addr 4094 ctrl 010, and p0 lw ctrl 111.
//     -> ack with err=1, m_w_en never high, rdata 0, memory unchanged.
//  5. p0 sw addr 0xFFFFFFFF ctrl 001.
//     -> err=1 (no 32-bit wrap); sw at 4093 ctrl 010 -> err=0.
//  6. Assert RST during ACCESS of a p0 store.
//     -> no p0_ack; busy=0 next cycle; data written; next request is served normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the single-port data memory.
// Each access runs IDLE -> ACCESS -> DONE. The request is latched in IDLE, dmem is
// driven in ACCESS, and the response is presented for exactly one cycle in DONE.
// Illegal ctrl codes and out-of-range addresses complete with err=1 and never write dmem.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   pX_req/we/addr/wdata/ctrl requester X inputs (X = 0 CPU LSU, X = 1 loader/debug)
//   pX_ack/err/rdata         requester X one-cycle response
//   m_addr/w_data/ctrl/w_en  dmem request, m_outdata combinational dmem read data
//   busy, grant_id           sequencer active / port owning current or last access
module dmem_arbiter #(
    parameter int unsigned ADDR_LIMIT = 4096,
    parameter bit          PRIO_FIXED = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [2:0]  p0_ctrl,
    output logic        p0_ack,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [2:0]  p1_ctrl,
    output logic        p1_ack,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    output logic [31:0] m_addr,
    output logic [31:0] m_w_data,
    output logic [2:0]  m_ctrl,
    output logic        m_w_en,
    input  logic [31:0] m_outdata,
    output logic        busy,
    output logic        grant_id
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 3;
    localparam int unsigned EW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]   ctrl_q, ctrl_d;
    logic            err_q, err_d;
    logic            grant_q, grant_d;
    logic            ack0_q, ack0_d, err0_q, err0_d;
    logic            ack1_q, ack1_d, err1_q, err1_d;
    logic [DW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic            busy_q, wen_q;

    logic            win_c;
    logic            sel_we_c;
    logic [AW-1:0]   sel_addr_c;
    logic [DW-1:0]   sel_wdata_c;
    logic [CW-1:0]   sel_ctrl_c;
    logic [2:0]      size_c;
    logic [EW-1:0]   last_byte_c;
    logic            bad_c;
    logic [DW-1:0]   resp_data_c;

    // Winner: a lone requester wins; a tie goes to port 0 (fixed) or the port not granted last.
    assign win_c = (p0_req & p1_req) ? (PRIO_FIXED ? 1'b0 : ~grant_q) : p1_req;

    // Winner's request fields and legality check (33-bit end address so it cannot wrap).
    always_comb begin
        sel_we_c    = win_c ? p1_we    : p0_we;
        sel_addr_c  = win_c ? p1_addr  : p0_addr;
        sel_wdata_c = win_c ? p1_wdata : p0_wdata;
        sel_ctrl_c  = win_c ? p1_ctrl  : p0_ctrl;
        size_c      = 3'd0;
        case (sel_ctrl_c)
            3'b000, 3'b100: size_c = 3'd1;
            3'b001, 3'b101: size_c = 3'd2;
            3'b010:         size_c = 3'd4;
            default:        size_c = 3'd0;
        endcase
        last_byte_c = {1'b0, sel_addr_c} + EW'(size_c) - EW'(1);
        bad_c       = (size_c == 3'd0) | (last_byte_c > EW'(ADDR_LIMIT));
    end

    // Loads return dmem data; stores and rejected accesses return zero.
    assign resp_data_c = (we_q | err_q) ? '0 : m_outdata;

    // Next-state and response logic.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ctrl_d   = ctrl_q;
        err_d    = err_q;
        grant_d  = grant_q;
        ack0_d   = 1'b0;
        err0_d   = 1'b0;
        rdata0_d = rdata0_q;
        ack1_d   = 1'b0;
        err1_d   = 1'b0;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (p0_req | p1_req) begin
                    we_d    = sel_we_c;
                    addr_d  = sel_addr_c;
                    wdata_d = sel_wdata_c;
                    ctrl_d  = sel_ctrl_c;
                    err_d   = bad_c;
                    grant_d = win_c;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (grant_q) begin
                    ack1_d   = 1'b1;
                    err1_d   = err_q;
                    rdata1_d = resp_data_c;
                end else begin
                    ack0_d   = 1'b1;
                    err0_d   = err_q;
                    rdata0_d = resp_data_c;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; busy and write enable are registered from the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ctrl_q   <= '0;
            err_q    <= 1'b0;
            grant_q  <= 1'b1;
            ack0_q   <= 1'b0;
            err0_q   <= 1'b0;
            rdata0_q <= '0;
            ack1_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
            wen_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ctrl_q   <= ctrl_d;
            err_q    <= err_d;
            grant_q  <= grant_d;
            ack0_q   <= ack0_d;
            err0_q   <= err0_d;
            rdata0_q <= rdata0_d;
            ack1_q   <= ack1_d;
            err1_q   <= err1_d;
            rdata1_q <= rdata1_d;
            busy_q   <= (state_d != IDLE);
            wen_q    <= (state_d == ACCESS) & we_d & ~err_d;
        end
    end

    assign p0_ack   = ack0_q;
    assign p0_err   = err0_q;
    assign p0_rdata = rdata0_q;
    assign p1_ack   = ack1_q;
    assign p1_err   = err1_q;
    assign p1_rdata = rdata1_q;
    assign m_addr   = addr_q;
    assign m_w_data = wdata_q;
    assign m_ctrl   = ctrl_q;
    assign m_w_en   = wen_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;

endmodule
